// File: rtl/lcd_pkg.sv
// Shared constants, state types and the nibble-to-ASCII helper for the
// HD44780 hex writer and its bus transfer engine.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_HOME     = 8'h80;
    localparam logic [7:0] CHR_ZERO     = 8'h30;
    localparam logic [7:0] CHR_X        = 8'h78;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_HOME,
        ST_CHARS,
        ST_GAP
    } lcd_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_PULSE,
        PH_WAIT
    } xfer_phase_e;

    // 8-bit sum, carry discarded: 0-9 -> '0'..'9', A-F -> 'A'..'F'
    function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
        logic [7:0] n8;
        n8 = {4'h0, n};
        return (n < 4'd10) ? (8'h30 + n8) : (8'h37 + n8);
    endfunction

endpackage

// File: rtl/lcd_hex_writer_if.sv
// Parallel HD44780 write bus bundle: byte lanes plus RS/RW/E strobes.
interface lcd_hex_writer_if;

    logic [7:0] DATA_BUS;
    logic       LCD_RW;
    logic       LCD_E;
    logic       LCD_RS;

    modport master (output DATA_BUS, LCD_RW, LCD_E, LCD_RS);
    modport slave  (input  DATA_BUS, LCD_RW, LCD_E, LCD_RS);

endinterface

// File: rtl/lcd_bus_xfer.sv
// One LCD write: setup cycle, E pulse, then a short or long settle wait.
// done fires in the last wait cycle so a back-to-back start costs no bubble.
module lcd_bus_xfer
    import lcd_pkg::*;
#(
    parameter int unsigned E_PULSE_CYC    = 16,
    parameter int unsigned CHAR_WAIT_CYC  = 2500,
    parameter int unsigned CLEAR_WAIT_CYC = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             rs,
    input  logic [7:0]       data,
    input  logic             long_wait,
    output logic             done,
    lcd_hex_writer_if.master bus
);

    xfer_phase_e phase_q, phase_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        e_q, e_d;
    logic        long_q, long_d;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        e_d     = e_q;
        long_d  = long_q;
        done    = 1'b0;
        case (phase_q)
            PH_SETUP: begin
                phase_d = PH_PULSE;
                e_d     = 1'b1;
                cnt_d   = 32'(E_PULSE_CYC - 1);
            end
            PH_PULSE: begin
                if (cnt_q == '0) begin
                    e_d     = 1'b0;
                    phase_d = PH_WAIT;
                    cnt_d   = long_q ? 32'(CLEAR_WAIT_CYC - 1) : 32'(CHAR_WAIT_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            PH_WAIT: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    phase_d = PH_IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: ;
        endcase
        // Data and RS change only here, so they stay put through the whole wait
        if (start && (phase_q == PH_IDLE || done)) begin
            phase_d = PH_SETUP;
            data_d  = data;
            rs_d    = rs;
            long_d  = long_wait;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
            long_q  <= long_d;
        end
    end

    assign bus.DATA_BUS = data_q;
    assign bus.LCD_RS   = rs_q;
    assign bus.LCD_E    = e_q;
    assign bus.LCD_RW   = 1'b0;

endmodule

// File: rtl/lcd_hex_writer.sv
// Shows reg_msg as "0xHHHH" on line 1 of a 16x2 HD44780 display.
// LCD_CHANGE_ONLY_EN: redraw only when reg_msg differs from the shown value.
module lcd_hex_writer
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_WAIT_CYC = 2500000,
    parameter int unsigned E_PULSE_CYC      = 16,
    parameter int unsigned CHAR_WAIT_CYC    = 2500,
    parameter int unsigned CLEAR_WAIT_CYC   = 100000,
    parameter int unsigned REFRESH_CYC      = 5000000
) (
    input  logic        iCLK_50MHZ,
    input  logic        iRST_N,
    input  logic [15:0] reg_msg,
    inout  wire  [7:0]  DATA_BUS,
    output logic        LCD_RW,
    output logic        LCD_E,
    output logic        LCD_RS,
    output logic        oFRAME_DONE
);

    lcd_state_e  st_q, st_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] shown_q, shown_d;
    logic        fd_q, fd_d;
    logic        xfer_start, xfer_rs, xfer_long, xfer_done;
    logic [7:0]  xfer_byte;

    always_comb begin
        st_d       = st_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        shown_d    = shown_q;
        fd_d       = 1'b0;
        xfer_start = 1'b0;
        case (st_q)
            ST_PWRUP: begin
                if (cnt_q == 32'(POWERUP_WAIT_CYC - 1)) begin
                    st_d       = ST_INIT;
                    idx_d      = 3'd0;
                    xfer_start = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_INIT: begin
                if (xfer_done) begin
                    xfer_start = 1'b1;
                    if (idx_q == 3'd3) begin
                        st_d    = ST_HOME;
                        idx_d   = 3'd0;
                        shown_d = reg_msg;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_HOME: begin
                if (xfer_done) begin
                    st_d       = ST_CHARS;
                    idx_d      = 3'd0;
                    xfer_start = 1'b1;
                end
            end
            ST_CHARS: begin
                if (xfer_done) begin
                    if (idx_q == 3'd5) begin
                        st_d  = ST_GAP;
                        fd_d  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        xfer_start = 1'b1;
                    end
                end
            end
            ST_GAP: begin
`ifdef LCD_CHANGE_ONLY_EN
                if (reg_msg != shown_q) begin
                    st_d       = ST_HOME;
                    shown_d    = reg_msg;
                    xfer_start = 1'b1;
                end
`else
                if (cnt_q == 32'(REFRESH_CYC - 1)) begin
                    st_d       = ST_HOME;
                    shown_d    = reg_msg;
                    xfer_start = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            default: st_d = ST_PWRUP;
        endcase

        // Byte is chosen from the step being entered, so a start issued on done
        // carries the next byte in the same cycle.
        xfer_rs   = 1'b0;
        xfer_long = 1'b0;
        xfer_byte = CMD_HOME;
        case (st_d)
            ST_INIT: begin
                case (idx_d)
                    3'd0:    xfer_byte = CMD_FUNC_SET;
                    3'd1:    xfer_byte = CMD_DISP_ON;
                    3'd2: begin
                        xfer_byte = CMD_CLEAR;
                        xfer_long = 1'b1;
                    end
                    default: xfer_byte = CMD_ENTRY;
                endcase
            end
            ST_CHARS: begin
                xfer_rs = 1'b1;
                case (idx_d)
                    3'd0:    xfer_byte = CHR_ZERO;
                    3'd1:    xfer_byte = CHR_X;
                    3'd2:    xfer_byte = nib_to_ascii(shown_q[15:12]);
                    3'd3:    xfer_byte = nib_to_ascii(shown_q[11:8]);
                    3'd4:    xfer_byte = nib_to_ascii(shown_q[7:4]);
                    default: xfer_byte = nib_to_ascii(shown_q[3:0]);
                endcase
            end
            default: xfer_byte = CMD_HOME;
        endcase
    end

    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            st_q    <= ST_PWRUP;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            shown_q <= 16'h0000;
            fd_q    <= 1'b0;
        end else begin
            st_q    <= st_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            shown_q <= shown_d;
            fd_q    <= fd_d;
        end
    end

    lcd_hex_writer_if lcd_bus ();

    lcd_bus_xfer #(
        .E_PULSE_CYC   (E_PULSE_CYC),
        .CHAR_WAIT_CYC (CHAR_WAIT_CYC),
        .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
    ) u_xfer (
        .clk      (iCLK_50MHZ),
        .rst_n    (iRST_N),
        .start    (xfer_start),
        .rs       (xfer_rs),
        .data     (xfer_byte),
        .long_wait(xfer_long),
        .done     (xfer_done),
        .bus      (lcd_bus)
    );

    assign DATA_BUS    = lcd_bus.DATA_BUS;
    assign LCD_RW      = lcd_bus.LCD_RW;
    assign LCD_E       = lcd_bus.LCD_E;
    assign LCD_RS      = lcd_bus.LCD_RS;
    assign oFRAME_DONE = fd_q;

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Bench for lcd_hex_writer: transfer-level model of the expected LCD byte
// stream and bus timing, checked every cycle, plus literal frame contents.
module tb_lcd_hex_writer;

    localparam int PW = 10;
    localparam int EP = 4;
    localparam int CW = 8;
    localparam int LW = 20;
    localparam int RF = 16;
`ifdef LCD_CHANGE_ONLY_EN
    localparam bit CHG_ONLY = 1'b1;
`else
    localparam bit CHG_ONLY = 1'b0;
`endif

    typedef struct {
        logic       rs;
        logic [7:0] b;
        bit         lng;
        bit         fend;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] reg_msg = 16'h0000;
    wire  [7:0]  data_bus;
    logic        frame_done;

    lcd_hex_writer_if mon ();
    assign mon.DATA_BUS = data_bus;

    lcd_hex_writer #(
        .POWERUP_WAIT_CYC(PW),
        .E_PULSE_CYC     (EP),
        .CHAR_WAIT_CYC   (CW),
        .CLEAR_WAIT_CYC  (LW),
        .REFRESH_CYC     (RF)
    ) dut (
        .iCLK_50MHZ (clk),
        .iRST_N     (rst_n),
        .reg_msg    (reg_msg),
        .DATA_BUS   (data_bus),
        .LCD_RW     (mon.LCD_RW),
        .LCD_E      (mon.LCD_E),
        .LCD_RS     (mon.LCD_RS),
        .oFRAME_DONE(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int fd_cnt = 0;
    logic [7:0] log_q[$];
    xfer_t expq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        int v;
        v = int'(n);
        if (v < 10) return 8'(48 + v);
        return 8'(65 + v - 10);
    endfunction

    function automatic xfer_t mk(input logic rs, input logic [7:0] b, input bit lng, input bit fend);
        xfer_t t;
        t.rs = rs; t.b = b; t.lng = lng; t.fend = fend;
        return t;
    endfunction

    task automatic push_init();
        expq.push_back(mk(1'b0, 8'h38, 1'b0, 1'b0));
        expq.push_back(mk(1'b0, 8'h0C, 1'b0, 1'b0));
        expq.push_back(mk(1'b0, 8'h01, 1'b1, 1'b0));
        expq.push_back(mk(1'b0, 8'h06, 1'b0, 1'b0));
    endtask

    task automatic push_frame(input logic [15:0] v);
        expq.push_back(mk(1'b0, 8'h80, 1'b0, 1'b0));
        expq.push_back(mk(1'b1, 8'h30, 1'b0, 1'b0));
        expq.push_back(mk(1'b1, 8'h78, 1'b0, 1'b0));
        expq.push_back(mk(1'b1, hex_char(v[15:12]), 1'b0, 1'b0));
        expq.push_back(mk(1'b1, hex_char(v[11:8]), 1'b0, 1'b0));
        expq.push_back(mk(1'b1, hex_char(v[7:4]), 1'b0, 1'b0));
        expq.push_back(mk(1'b1, hex_char(v[3:0]), 1'b0, 1'b1));
    endtask

    // Model state, owned by the compare process
    int    cyc = 0;
    int    last_rise = -1;
    int    fd_due = -1;
    int    high_cnt = 0;
    bit    prev_long = 1'b0;
    bit    prev_end = 1'b0;
    logic  prev_e = 1'b0;
    logic  prev_rs = 1'b0;
    logic [7:0] prev_data = 8'h00;
    xfer_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_e", mon.LCD_E, 1'b0);
            chk("reset_rs", mon.LCD_RS, 1'b0);
            chk("reset_rw", mon.LCD_RW, 1'b0);
            chk("reset_data", mon.DATA_BUS, 8'h00);
            chk("reset_frame_done", frame_done, 1'b0);
            expq.delete();
            push_init();
            cyc = 0;
            last_rise = -1;
            fd_due = -1;
            high_cnt = 0;
            prev_long = 1'b0;
            prev_end = 1'b0;
        end else begin
            cyc++;
            chk("rw_low", mon.LCD_RW, 1'b0);
            chk("frame_done", frame_done, (cyc == fd_due));
            if (frame_done) fd_cnt++;
            if (mon.LCD_E && !prev_e) begin
                if (expq.size() == 0) push_frame(reg_msg);
                cur = expq.pop_front();
                chk("byte", mon.DATA_BUS, cur.b);
                chk("rs", mon.LCD_RS, cur.rs);
                chk("setup_data", prev_data, mon.DATA_BUS);
                chk("setup_rs", prev_rs, mon.LCD_RS);
                if (last_rise < 0)
                    chk("powerup_wait", cyc, PW + 1);
                else if (!(CHG_ONLY && prev_end))
                    chk("transfer_interval", cyc - last_rise,
                        1 + EP + (prev_long ? LW : CW) + (prev_end ? RF : 0));
                last_rise = cyc;
                prev_long = cur.lng;
                prev_end = cur.fend;
                high_cnt = 1;
                if (cur.fend) fd_due = cyc + EP + CW;
                log_q.push_back(mon.DATA_BUS);
            end else if (mon.LCD_E) begin
                high_cnt++;
                chk("data_hold", mon.DATA_BUS, cur.b);
                chk("rs_hold", mon.LCD_RS, cur.rs);
            end else if (prev_e) begin
                chk("pulse_width", high_cnt, EP);
            end
        end
        prev_e = mon.LCD_E;
        prev_rs = mon.LCD_RS;
        prev_data = mon.DATA_BUS;
    end

    task automatic wait_fd(input int target, input int budget);
        int n = 0;
        while (fd_cnt < target && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (fd_cnt < target) chk("timeout_frame", fd_cnt, target);
    endtask

    task automatic wait_log(input int target, input int budget);
        int n = 0;
        while (log_q.size() < target && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (log_q.size() < target) chk("timeout_log", log_q.size(), target);
    endtask

    task automatic wait_e_high(input int budget);
        int n = 0;
        @(posedge clk); #2;
        while (!mon.LCD_E && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (!mon.LCD_E) chk("timeout_e_high", mon.LCD_E, 1'b1);
    endtask

    initial begin
        logic [7:0] exp1 [0:10];
        logic [7:0] exp4 [0:6];
        logic [7:0] exp5 [0:3];
        int sz;
        int fdb;
        exp1 = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80, 8'h30, 8'h78, 8'h31, 8'h41, 8'h39, 8'h46};
        exp4 = '{8'h80, 8'h30, 8'h78, 8'h30, 8'h30, 8'h43, 8'h33};
        exp5 = '{8'h31, 8'h32, 8'h33, 8'h34};

        rst_n = 1'b0;
        reg_msg = 16'h1A9F;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Init sequence and first frame of 0x1A9F
        wait_fd(1, 600);
        for (int i = 0; i < 11; i++) chk("frame1_byte", log_q[i], exp1[i]);
        chk("frame1_done_count", fd_cnt, 1);

        // Snapshot coherency: 0x0000 frame, 0xFFFF applied after its 3rd digit
        reg_msg = 16'h0000;
        wait_log(17, 600);
        reg_msg = 16'hFFFF;
        wait_fd(3, 600);
        for (int i = 14; i < 18; i++) chk("snapshot_old_digit", log_q[i], 8'h30);
        for (int i = 21; i < 25; i++) chk("snapshot_new_digit", log_q[i], 8'h46);

`ifdef LCD_CHANGE_ONLY_EN
        sz = log_q.size();
        repeat (1000) @(negedge clk);
        #1 chk("silent_bus", log_q.size(), sz);
`endif

        reg_msg = 16'h00C3;
        wait_fd(4, 1500);
        sz = log_q.size();
        for (int i = 0; i < 7; i++) chk("frame_00c3_byte", log_q[sz - 7 + i], exp4[i]);

        // Reset while E is high, then full restart
        reg_msg = 16'h1234;
        wait_e_high(400);
        rst_n = 1'b0;
        #1 chk("e_async_drop", mon.LCD_E, 1'b0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        fdb = fd_cnt;
        wait_fd(fdb + 1, 600);
        sz = log_q.size();
        chk("restart_first_cmd", log_q[sz - 11], 8'h38);
        for (int i = 0; i < 4; i++) chk("restart_digit", log_q[sz - 4 + i], exp5[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_hex_writer.md
# lcd_hex_writer

Drives a 16x2 HD44780-compatible character LCD over the 8-bit parallel bus and shows a registered 16-bit value as "0x" followed by four upper-case hex digits on line 1. Sits directly downstream of the top-level LCD wrapper, consuming its registered `reg_msg`. It runs the power-up wait, the controller init sequence and the periodic refresh, and owns all bus timing.

## Interface
- `POWERUP_WAIT_CYC`, default 2500000: cycles waited after reset before the first command (50 ms at 50 MHz).
- `E_PULSE_CYC`, default 16: cycles `LCD_E` is held high per transfer.
- `CHAR_WAIT_CYC`, default 2500: cycles waited after each transfer except Clear (50 µs).
- `CLEAR_WAIT_CYC`, default 100000: cycles waited after Clear (0x01) (2 ms).
- `REFRESH_CYC`, default 5000000: idle gap between frames in continuous mode (100 ms).
- `iCLK_50MHZ` in 1: the single clock.
- `iRST_N` in 1: asynchronous, active-low reset.
- `reg_msg` in 16: value to display. It is already registered upstream.
- `DATA_BUS` inout 8: LCD data. Always driven; this block never reads the bus.
- `LCD_RW` out 1: constant 0 (write).
- `LCD_E` out 1: enable strobe.
- `LCD_RS` out 1: 0 = command, 1 = data.
- `oFRAME_DONE` out 1: one-cycle pulse when the last digit's wait completes.

## Operation
- **States:** PWRUP → INIT → HOME → CHARS → GAP → HOME …
- **PWRUP:** wait `POWERUP_WAIT_CYC` cycles.
- **INIT:** send commands, RS=0, in this order:
  - 0x38 (8-bit, 2 lines, 5x8)
  - 0x0C (display on, cursor off)
  - 0x01 (clear; followed by `CLEAR_WAIT_CYC`)
  - 0x06 (increment, no shift)
- **HOME:**
  - On entry, snapshot `reg_msg` into the `shown` register.
  - Send command 0x80 (DDRAM address 0).
- **CHARS:** send 6 data bytes, RS=1: 0x30, 0x78, then digits of `shown[15:12]`, `[11:8]`, `[7:4]`, `[3:0]`.
- **Digit encoding:** nibble n < 10 → 0x30+n; otherwise 0x37+n (A=0x41 … F=0x46). Use 8-bit arithmetic with no carry out.
- **Snapshot rule:** a frame always shows one coherent snapshot. `reg_msg` changes during a frame are ignored until the next HOME.
- **GAP:** behaviour depends on Configuration. Pulse `oFRAME_DONE` on leaving CHARS.
- **Reset mid-operation:**
  - `LCD_E` drops asynchronously, even mid-pulse.
  - All state returns to PWRUP and the full init sequence is repeated.

## Timing
- **Reset values:**
  - `LCD_E`=0, `LCD_RS`=0, `LCD_RW`=0, `DATA_BUS`=0x00, `oFRAME_DONE`=0.
  - `shown`=0x0000, state = PWRUP.
- **One transfer, from start cycle T:**
  - T: `DATA_BUS` and `LCD_RS` update.
  - T+1: `LCD_E` rises.
  - T+1+`E_PULSE_CYC`: `LCD_E` falls.
  - `DATA_BUS`/`LCD_RS` stay stable until the next transfer's start cycle.
  - The wait count begins the cycle `LCD_E` falls.
  - The next transfer starts `CHAR_WAIT_CYC` (or `CLEAR_WAIT_CYC`) cycles after the fall.
- **Transfer length:** 1 + `E_PULSE_CYC` + wait cycles. `LCD_E` never rises twice without a full wait in between.
- **Frame latency:** a `reg_msg` change is visible on the bus, as the first digit, no later than one GAP + HOME + 2 transfers after the next HOME entry.
- **`oFRAME_DONE`:** high for exactly the cycle after the 6th character's wait expires.

## Configuration
- **`LCD_CHANGE_ONLY_EN` defined:** GAP has no timer.
  - Stay in GAP until `reg_msg != shown`, then go to HOME on the next cycle.
  - If the value never changes, the bus is silent after the first frame.
- **`LCD_CHANGE_ONLY_EN` undefined:** GAP waits `REFRESH_CYC` cycles, then goes to HOME unconditionally (continuous refresh).
- Init and all bus timing are identical in both builds.

## Structure
- **Shared package `lcd_pkg`:**
  - Command constants: 0x38, 0x0C, 0x01, 0x06, 0x80.
  - Character constants: 0x30, 0x78.
  - State enum type.
  - Nibble-to-ASCII function.
- **Sub-module `lcd_bus_xfer`:**
  - Inputs: start pulse, RS, byte, long-wait select.
  - Drives `DATA_BUS`/`LCD_RS`/`LCD_E` and returns a one-cycle `done`.
  - The top-level sequencer only chooses bytes.

## Test plan
All scenarios use `POWERUP_WAIT_CYC`=10, `E_PULSE_CYC`=4, `CHAR_WAIT_CYC`=8, `CLEAR_WAIT_CYC`=20, `REFRESH_CYC`=16.

- **Reset and init:** release reset → `LCD_E` stays 0 for 10 cycles. Then E pulses capture, with RS=0: 0x38, 0x0C, 0x01, 0x06, 0x80. The gap after 0x01's fall is 20 cycles; all others are 8.
- **Digit encoding:** `reg_msg`=0x1A9F → RS=1 captures 0x30, 0x78, 0x31, 0x41, 0x39, 0x46 → `oFRAME_DONE` pulses once.
- **Pulse width:** every `LCD_E` high is exactly 4 cycles; `DATA_BUS` is stable from one cycle before the rise to the fall.
- **Snapshot coherency:** change `reg_msg` 0x0000→0xFFFF between the 3rd and 4th digits → the frame shows 0x30, 0x30, 0x30, 0x30; the next frame shows 0x46 ×4.
- **Reset mid-pulse:** assert `iRST_N`=0 while `LCD_E`=1 → `LCD_E`=0 in the same cycle. After release, the sequence restarts with the 10-cycle wait and 0x38.
- **`LCD_CHANGE_ONLY_EN` build:** `reg_msg` held constant → no `LCD_E` edge for 1000 cycles after the first frame. Change it to 0x00C3 → HOME 0x80 follows, then digits 0x30, 0x30, 0x43, 0x33.
